// File: rtl/instr_encoder_loader_if.sv
// Program-source and instruction-memory signals of the instruction encoder/loader.
// The loader sits on the slave modport; the program source and memory model sit on the master.
interface instr_encoder_loader_if #(
   parameter int AW = 8,
   parameter int CW = 8
);
   logic          start;
   logic [AW-1:0] base_addr;
   logic [CW-1:0] count;
   logic          in_valid;
   logic          in_ready;
   logic [6:0]    opcode;
   logic [4:0]    dr;
   logic [4:0]    sa;
   logic [4:0]    sb;
   logic [14:0]   imm;
   logic          use_imm;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic          mem_ready;
   logic          busy;
   logic          done;

   modport master (
      output start, base_addr, count, in_valid, opcode, dr, sa, sb, imm, use_imm, mem_ready,
      input  in_ready, mem_we, mem_addr, mem_wdata, busy, done
   );

   modport slave (
      input  start, base_addr, count, in_valid, opcode, dr, sa, sb, imm, use_imm, mem_ready,
      output in_ready, mem_we, mem_addr, mem_wdata, busy, done
   );
endinterface

// File: rtl/instr_encoder_loader.sv
// Packs field tuples into 32-bit IR words and writes them to consecutive
// instruction-memory addresses, one outstanding word at a time.
module instr_encoder_loader #(
   parameter int AW = 8,
   parameter int CW = 8
) (
   input logic                   i_clk,
   input logic                   i_rst,
   instr_encoder_loader_if.slave bus
);
   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WRITE, S_DONE} state_t;

   state_t        r_state;
   state_t        w_next;
   logic [AW-1:0] r_addr;
   logic [CW-1:0] r_remaining;
   logic [31:0]   r_wdata;
   logic [31:0]   w_packed;
   logic          w_start_ok;
   logic          w_accept;
   logic          w_wr_fire;

   // Immediate format overlays the sb slot and the 10 zero bits below it.
   assign w_packed   = bus.use_imm ? {bus.opcode, bus.dr, bus.sa, bus.imm}
                                   : {bus.opcode, bus.dr, bus.sa, bus.sb, 10'b0};
   assign w_start_ok = (r_state == S_IDLE)  && bus.start;
   assign w_accept   = (r_state == S_LOAD)  && bus.in_valid;
   assign w_wr_fire  = (r_state == S_WRITE) && bus.mem_ready;

   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (bus.start) w_next = (bus.count != '0) ? S_LOAD : S_DONE;
         S_LOAD:  if (bus.in_valid) w_next = S_WRITE;
         S_WRITE: if (bus.mem_ready) w_next = (r_remaining == CW'(1)) ? S_DONE : S_LOAD;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      bus.in_ready  = (r_state == S_LOAD);
      bus.mem_we    = (r_state == S_WRITE);
      bus.busy      = (r_state != S_IDLE);
      bus.done      = (r_state == S_DONE);
      bus.mem_addr  = r_addr;
      bus.mem_wdata = r_wdata;
   end

   // Address wraps naturally at 2^AW.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_addr      <= '0;
         r_remaining <= '0;
         r_wdata     <= '0;
      end else begin
         if (w_start_ok && (bus.count != '0)) begin
            r_addr      <= bus.base_addr;
            r_remaining <= bus.count;
         end
         if (w_accept) r_wdata <= w_packed;
         if (w_wr_fire) begin
            r_addr      <= r_addr + AW'(1);
            r_remaining <= r_remaining - CW'(1);
         end
      end
   end
endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed plus randomized loads of instr_encoder_loader, checked against an
// arithmetic model of IR packing and sequential address assignment.
module tb_instr_encoder_loader;
   localparam int AW = 8;
   localparam int CW = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   instr_encoder_loader_if #(.AW(AW), .CW(CW)) bus();

   instr_encoder_loader #(.AW(AW), .CW(CW)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus.slave)
   );

   int n_checks = 0;
   int n_errors = 0;

   int t_opc[16], t_dr[16], t_sa[16], t_sb[16], t_imm[16], t_ui[16];

   // Every accepted memory write, as {addr, data}.
   logic [AW+31:0] wr_q[$];
   always @(posedge clk)
      if (!rst && bus.mem_we && bus.mem_ready) wr_q.push_back({bus.mem_addr, bus.mem_wdata});

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model_word(input int i);
      longint unsigned w;
      w = longint'(t_opc[i]) * 33554432 + longint'(t_dr[i]) * 1048576 + longint'(t_sa[i]) * 32768;
      if (t_ui[i] != 0) w = w + longint'(t_imm[i]);
      else              w = w + longint'(t_sb[i]) * 1024;
      return w[31:0];
   endfunction

   task automatic gen_tuples(input int n);
      for (int i = 0; i < n; i++) begin
         t_opc[i] = $urandom_range(0, 127);
         t_dr[i]  = $urandom_range(0, 31);
         t_sa[i]  = $urandom_range(0, 31);
         t_sb[i]  = $urandom_range(0, 31);
         t_imm[i] = $urandom_range(0, 32767);
         t_ui[i]  = $urandom_range(0, 1);
      end
   endtask

   task automatic scramble();
      bus.opcode  = 7'($urandom);
      bus.dr      = 5'($urandom);
      bus.sa      = 5'($urandom);
      bus.sb      = 5'($urandom);
      bus.imm     = 15'($urandom);
      bus.use_imm = 1'($urandom);
   endtask

   // One complete load; all sampling and driving happens on the falling edge.
   task automatic do_load(input int base, input int cnt, input int st_max, input int st_min,
                          input int gap_max, input int restart_at);
      int w0, stall, gap, ea;
      logic [31:0] ed;
      w0 = wr_q.size();
      @(negedge clk);
      bus.start = 1'b1; bus.base_addr = AW'(base); bus.count = CW'(cnt);
      @(negedge clk);
      bus.start = 1'b0; bus.base_addr = AW'($urandom); bus.count = CW'($urandom);
      chk("busy_after_start", 64'(bus.busy), 64'd1);
      if (cnt == 0) begin
         chk("empty_done", 64'(bus.done), 64'd1);
         chk("empty_we", 64'(bus.mem_we), 64'd0);
         chk("empty_in_ready", 64'(bus.in_ready), 64'd0);
         @(negedge clk);
         chk("empty_done_gone", 64'(bus.done), 64'd0);
         chk("empty_busy_gone", 64'(bus.busy), 64'd0);
         chk("empty_no_write", 64'(wr_q.size() - w0), 64'd0);
         return;
      end
      for (int i = 0; i < cnt; i++) begin
         gap = $urandom_range(0, gap_max);
         bus.in_valid = 1'b0;
         for (int g = 0; g < gap; g++) begin
            bus.mem_ready = 1'($urandom);
            chk("gap_in_ready", 64'(bus.in_ready), 64'd1);
            @(negedge clk);
         end
         chk("load_in_ready", 64'(bus.in_ready), 64'd1);
         chk("load_we", 64'(bus.mem_we), 64'd0);
         bus.in_valid = 1'b1;
         bus.mem_ready = 1'($urandom);
         bus.opcode = 7'(t_opc[i]); bus.dr = 5'(t_dr[i]); bus.sa = 5'(t_sa[i]);
         bus.sb = 5'(t_sb[i]); bus.imm = 15'(t_imm[i]); bus.use_imm = 1'(t_ui[i]);
         if (i == restart_at) begin
            bus.start = 1'b1; bus.base_addr = 8'h40; bus.count = 8'd5;
         end
         @(negedge clk);
         bus.in_valid = 1'b0; bus.start = 1'b0;
         scramble();
         ea = (base + i) % (1 << AW);
         ed = model_word(i);
         stall = $urandom_range(st_max, st_min);
         bus.mem_ready = (stall == 0);
         chk("write_we", 64'(bus.mem_we), 64'd1);
         chk("write_in_ready", 64'(bus.in_ready), 64'd0);
         chk("write_addr", 64'(bus.mem_addr), 64'(ea));
         chk("write_data", 64'(bus.mem_wdata), 64'(ed));
         for (int s = 1; s <= stall; s++) begin
            @(negedge clk);
            if (s == 2) bus.start = 1'b1;
            else        bus.start = 1'b0;
            chk("stall_we", 64'(bus.mem_we), 64'd1);
            chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
            chk("stall_addr", 64'(bus.mem_addr), 64'(ea));
            chk("stall_data", 64'(bus.mem_wdata), 64'(ed));
            chk("stall_no_write", 64'(wr_q.size() - w0), 64'(i));
            if (s == stall) bus.mem_ready = 1'b1;
         end
         @(negedge clk);
         bus.mem_ready = 1'b0; bus.start = 1'b0;
         chk("write_counted", 64'(wr_q.size() - w0), 64'(i + 1));
         chk("write_log", 64'(wr_q[wr_q.size() - 1]), 64'({AW'(ea), ed}));
      end
      chk("done_pulse", 64'(bus.done), 64'd1);
      chk("done_busy", 64'(bus.busy), 64'd1);
      chk("done_we", 64'(bus.mem_we), 64'd0);
      @(negedge clk);
      chk("done_gone", 64'(bus.done), 64'd0);
      chk("idle_busy", 64'(bus.busy), 64'd0);
      chk("total_writes", 64'(wr_q.size() - w0), 64'(cnt));
   endtask

   initial begin
      int w0;
      bus.start = 1'b0; bus.base_addr = '0; bus.count = '0; bus.in_valid = 1'b0;
      bus.mem_ready = 1'b0;
      scramble();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("rst_we", 64'(bus.mem_we), 64'd0);
      chk("rst_addr", 64'(bus.mem_addr), 64'd0);
      chk("rst_wdata", 64'(bus.mem_wdata), 64'd0);
      chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_done", 64'(bus.done), 64'd0);

      // Register form
      t_opc[0] = 2; t_dr[0] = 1; t_sa[0] = 2; t_sb[0] = 3; t_imm[0] = 32767; t_ui[0] = 0;
      t_opc[1] = 5; t_dr[1] = 4; t_sa[1] = 1; t_sb[1] = 3; t_imm[1] = 0;     t_ui[1] = 0;
      w0 = wr_q.size();
      do_load(8'h10, 2, 0, 0, 0, -1);
      chk("reg_form_w0", 64'(wr_q[w0]),     {24'd0, 8'h10, 32'h04110C00});
      chk("reg_form_w1", 64'(wr_q[w0 + 1]), {24'd0, 8'h11, 32'h0A408C00});

      // Immediate form, sb ignored
      t_opc[0] = 7; t_dr[0] = 1; t_sa[0] = 0; t_sb[0] = 31; t_imm[0] = 5; t_ui[0] = 1;
      w0 = wr_q.size();
      do_load(8'h20, 1, 0, 0, 0, -1);
      chk("imm_form", 64'(wr_q[w0][31:0]), 64'h0E100005);

      // Backpressure of exactly 4 cycles per write
      gen_tuples(2);
      do_load(8'h60, 2, 4, 4, 0, -1);

      // Address wrap, then empty load
      gen_tuples(2);
      w0 = wr_q.size();
      do_load(8'hFF, 2, 0, 0, 0, -1);
      chk("wrap_a0", 64'(wr_q[w0][39:32]), 64'hFF);
      chk("wrap_a1", 64'(wr_q[w0 + 1][39:32]), 64'h00);
      do_load(8'h33, 0, 0, 0, 0, -1);

      // Restart pulse mid-load is ignored
      gen_tuples(4);
      do_load(8'h50, 4, 3, 3, 0, 2);

      // Reset while a write is pending
      gen_tuples(1);
      @(negedge clk);
      bus.start = 1'b1; bus.base_addr = 8'h20; bus.count = 8'd3;
      @(negedge clk);
      bus.start = 1'b0; bus.in_valid = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0; bus.mem_ready = 1'b0;
      chk("pre_rst_we", 64'(bus.mem_we), 64'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid_rst_we", 64'(bus.mem_we), 64'd0);
      chk("mid_rst_busy", 64'(bus.busy), 64'd0);
      chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd0);
      gen_tuples(2);
      do_load(8'h30, 2, 0, 0, 0, -1);

      // Randomized loads with stalls and input gaps
      for (int r = 0; r < 8; r++) begin
         int c;
         c = $urandom_range(1, 8);
         gen_tuples(c);
         do_load(int'($urandom_range(0, 255)), c, 3, 0, 2, -1);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
